// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory bus between instruction fetch and data access.
// Data accesses win over fetches; every bus access is bounded by a timeout and freezes the pipeline.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_Req,
    input  logic [31:0] IF_Addr,
    output logic [31:0] IF_Data,
    output logic        IF_Valid,
    input  logic        MEM_MemRd,
    input  logic        MEM_MemWr,
    input  logic [31:0] MEM_Addr,
    input  logic [31:0] MEM_WrData,
    output logic [31:0] MEM_RdData,
    output logic        MEM_Valid,
    output logic        Bus_Req,
    output logic        Bus_Wr,
    output logic [31:0] Bus_Addr,
    output logic [31:0] Bus_WrData,
    input  logic [31:0] Bus_RdData,
    input  logic        Bus_Ack,
    output logic        Freeze,
    output logic        Bus_Err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             data_done_q, data_done_d;
    logic             if_done_q, if_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic [31:0]      if_data_q, if_data_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic             err_q, err_d;

    logic dpend, ipend, busy, timeout_hit, done_evt;

    always_comb begin
        dpend       = (MEM_MemRd | MEM_MemWr) & ~data_done_q;
        ipend       = IF_Req & ~if_done_q;
        busy        = (state_q != IDLE);
        timeout_hit = busy & ~Bus_Ack & (cnt_q == CNT_LAST);
        done_evt    = busy & (Bus_Ack | timeout_hit);
        Freeze      = reset & (dpend | ipend | busy);
    end

    always_comb begin
        state_d     = state_q;
        data_done_d = data_done_q;
        if_done_d   = if_done_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        if_data_d   = if_data_q;
        mem_data_d  = mem_data_q;
        err_d       = timeout_hit;

        case (state_q)
            IDLE: begin
                if (dpend) begin
                    state_d = DATA;
                    addr_d  = MEM_Addr;
                    wdata_d = MEM_WrData;
                    wr_d    = MEM_MemWr;
                    cnt_d   = '0;
                end else if (ipend) begin
                    state_d = FETCH;
                    addr_d  = IF_Addr;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    // Nothing pending and bus idle: Freeze is low, the pipeline advances.
                    data_done_d = 1'b0;
                    if_done_d   = 1'b0;
                end
            end
            DATA: begin
                if (done_evt) begin
                    data_done_d = 1'b1;
                    cnt_d       = '0;
                    if (!wr_q) begin
                        mem_data_d = Bus_Ack ? Bus_RdData : 32'h0;
                    end
                    if (ipend) begin
                        state_d = FETCH;
                        addr_d  = IF_Addr;
                        wr_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FETCH: begin
                if (done_evt) begin
                    if_done_d = 1'b1;
                    if_data_d = Bus_Ack ? Bus_RdData : 32'h0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            data_done_q <= 1'b0;
            if_done_q   <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wr_q        <= 1'b0;
            if_data_q   <= 32'h0;
            mem_data_q  <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_done_q <= data_done_d;
            if_done_q   <= if_done_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            if_data_q   <= if_data_d;
            mem_data_q  <= mem_data_d;
            err_q       <= err_d;
        end
    end

    assign Bus_Req    = busy;
    assign Bus_Wr     = wr_q;
    assign Bus_Addr   = addr_q;
    assign Bus_WrData = wdata_q;
    assign IF_Data    = if_data_q;
    assign IF_Valid   = if_done_q;
    assign MEM_RdData = mem_data_q;
    assign MEM_Valid  = data_done_q;
    assign Bus_Err    = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        IF_Req;
    logic [31:0] IF_Addr;
    logic [31:0] IF_Data;
    logic        IF_Valid;
    logic        MEM_MemRd;
    logic        MEM_MemWr;
    logic [31:0] MEM_Addr;
    logic [31:0] MEM_WrData;
    logic [31:0] MEM_RdData;
    logic        MEM_Valid;
    logic        Bus_Req;
    logic        Bus_Wr;
    logic [31:0] Bus_Addr;
    logic [31:0] Bus_WrData;
    logic [31:0] Bus_RdData;
    logic        Bus_Ack;
    logic        Freeze;
    logic        Bus_Err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Data(IF_Data), .IF_Valid(IF_Valid),
        .MEM_MemRd(MEM_MemRd), .MEM_MemWr(MEM_MemWr), .MEM_Addr(MEM_Addr),
        .MEM_WrData(MEM_WrData), .MEM_RdData(MEM_RdData), .MEM_Valid(MEM_Valid),
        .Bus_Req(Bus_Req), .Bus_Wr(Bus_Wr), .Bus_Addr(Bus_Addr), .Bus_WrData(Bus_WrData),
        .Bus_RdData(Bus_RdData), .Bus_Ack(Bus_Ack), .Freeze(Freeze), .Bus_Err(Bus_Err)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Model: which access owns the bus (0 none, 1 data, 2 fetch), how long it has waited,
    // what it put on the bus, and what the pipeline has been handed back so far.
    int          mBusy;
    int          mAge;
    logic [31:0] mAddr, mWrData, mIfData, mMemData;
    logic        mWr, mIfDone, mDataDone, mErr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic aIfReq, input logic [31:0] aIfAddr,
                                 input logic aRd, input logic aWr,
                                 input logic [31:0] aMemAddr, input logic [31:0] aWrData,
                                 input logic aAck, input logic [31:0] aRdData);
        IF_Req     = aIfReq;
        IF_Addr    = aIfAddr;
        MEM_MemRd  = aRd;
        MEM_MemWr  = aWr;
        MEM_Addr   = aMemAddr;
        MEM_WrData = aWrData;
        Bus_Ack    = aAck;
        Bus_RdData = aRdData;
    endtask

    task automatic modelReset();
        mBusy     = 0;
        mAge      = 0;
        mAddr     = 32'h0;
        mWrData   = 32'h0;
        mIfData   = 32'h0;
        mMemData  = 32'h0;
        mWr       = 1'b0;
        mIfDone   = 1'b0;
        mDataDone = 1'b0;
        mErr      = 1'b0;
    endtask

    task automatic startAccess(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic wr);
        mBusy   = kind;
        mAge    = 0;
        mAddr   = addr;
        mWrData = wdata;
        mWr     = wr;
    endtask

    function automatic logic expFreeze();
        return reset && ((((MEM_MemRd || MEM_MemWr) && !mDataDone)) || (IF_Req && !mIfDone) || (mBusy != 0));
    endfunction

    // Advances the model across one rising edge using the inputs held during the cycle.
    task automatic modelStep();
        logic        wantD, wantI, fin;
        logic [31:0] val;
        if (!reset) begin
            modelReset();
            return;
        end
        wantD = (MEM_MemRd || MEM_MemWr) && !mDataDone;
        wantI = IF_Req && !mIfDone;
        mErr  = 1'b0;
        if (mBusy != 0) begin
            fin = Bus_Ack || (mAge == TO - 1);
            if (fin) begin
                val  = Bus_Ack ? Bus_RdData : 32'h0;
                mErr = !Bus_Ack;
                if (mBusy == 1) begin
                    mDataDone = 1'b1;
                    if (!mWr) mMemData = val;
                    if (wantI) startAccess(2, IF_Addr, mWrData, 1'b0);
                    else mBusy = 0;
                end else begin
                    mIfDone = 1'b1;
                    mIfData = val;
                    mBusy   = 0;
                end
            end else begin
                mAge++;
            end
        end else if (wantD) begin
            startAccess(1, MEM_Addr, MEM_WrData, MEM_MemWr);
        end else if (wantI) begin
            startAccess(2, IF_Addr, mWrData, 1'b0);
        end else begin
            mIfDone   = 1'b0;
            mDataDone = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    always @(negedge clk) begin
        checkOutput("Freeze", {31'd0, Freeze}, {31'd0, expFreeze()});
        checkOutput("Bus_Req", {31'd0, Bus_Req}, {31'd0, (mBusy != 0)});
        checkOutput("IF_Valid", {31'd0, IF_Valid}, {31'd0, mIfDone});
        checkOutput("MEM_Valid", {31'd0, MEM_Valid}, {31'd0, mDataDone});
        checkOutput("IF_Data", IF_Data, mIfData);
        checkOutput("MEM_RdData", MEM_RdData, mMemData);
        checkOutput("Bus_Err", {31'd0, Bus_Err}, {31'd0, mErr});
        if (mBusy != 0) begin
            checkOutput("Bus_Addr", Bus_Addr, mAddr);
            checkOutput("Bus_Wr", {31'd0, Bus_Wr}, {31'd0, mWr});
            if (mWr) checkOutput("Bus_WrData", Bus_WrData, mWrData);
        end
    end

    initial begin
        bit ackNow;
        modelReset();
        reset = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        checkOutput("rst_Freeze", {31'd0, Freeze}, 32'd0);
        checkOutput("rst_Bus_Req", {31'd0, Bus_Req}, 32'd0);
        checkOutput("rst_Bus_Addr", Bus_Addr, 32'h0);
        checkOutput("rst_Bus_WrData", Bus_WrData, 32'h0);
        checkOutput("rst_Bus_Wr", {31'd0, Bus_Wr}, 32'd0);
        checkOutput("rst_IF_Data", IF_Data, 32'h0);
        checkOutput("rst_MEM_RdData", MEM_RdData, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        tick();

        // Fetch only, ack in cycle 2.
        applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("fo_c0_Freeze", {31'd0, Freeze}, 32'd1);
        checkOutput("fo_c0_Req", {31'd0, Bus_Req}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("fo_c1_Req", {31'd0, Bus_Req}, 32'd1);
        checkOutput("fo_c1_Addr", Bus_Addr, 32'h0040_0000);
        checkOutput("fo_c1_Wr", {31'd0, Bus_Wr}, 32'd0);
        tick();
        applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8C08_0004);
        @(negedge clk);
        checkOutput("fo_c2_Req", {31'd0, Bus_Req}, 32'd1);
        tick();
        applyStimulus(1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("fo_c3_IF_Data", IF_Data, 32'h8C08_0004);
        checkOutput("fo_c3_IF_Valid", {31'd0, IF_Valid}, 32'd1);
        checkOutput("fo_c3_Freeze", {31'd0, Freeze}, 32'd0);
        checkOutput("fo_c3_Req", {31'd0, Bus_Req}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();

        // Load and fetch together: data first, then fetch without passing through idle.
        applyStimulus(1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("lf_c0_Freeze", {31'd0, Freeze}, 32'd1);
        tick();
        applyStimulus(1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h55);
        @(negedge clk);
        checkOutput("lf_c1_Addr", Bus_Addr, 32'h10);
        checkOutput("lf_c1_Wr", {31'd0, Bus_Wr}, 32'd0);
        tick();
        applyStimulus(1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234);
        @(negedge clk);
        checkOutput("lf_c2_Req", {31'd0, Bus_Req}, 32'd1);
        checkOutput("lf_c2_Addr", Bus_Addr, 32'h0040_0004);
        checkOutput("lf_c2_MEM_RdData", MEM_RdData, 32'h55);
        checkOutput("lf_c2_MEM_Valid", {31'd0, MEM_Valid}, 32'd1);
        tick();
        applyStimulus(1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("lf_c3_IF_Data", IF_Data, 32'h1234);
        checkOutput("lf_c3_MEM_RdData", MEM_RdData, 32'h55);
        checkOutput("lf_c3_Freeze", {31'd0, Freeze}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();

        // Store with request inputs changing mid-access.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h99, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("st_c1_Wr", {31'd0, Bus_Wr}, 32'd1);
        checkOutput("st_c1_Addr", Bus_Addr, 32'h20);
        checkOutput("st_c1_WrData", Bus_WrData, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h99, 32'h0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("st_c2_Addr", Bus_Addr, 32'h20);
        checkOutput("st_c2_WrData", Bus_WrData, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h99, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("st_c3_MEM_Valid", {31'd0, MEM_Valid}, 32'd1);
        checkOutput("st_c3_MEM_RdData", MEM_RdData, 32'h55);
        checkOutput("st_c3_Freeze", {31'd0, Freeze}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();

        // Fetch that never gets an ack: request held TO cycles, then an error pulse.
        applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            checkOutput($sformatf("to_c%0d_Req", c), {31'd0, Bus_Req}, 32'd1);
            tick();
        end
        @(negedge clk);
        checkOutput("to_Req_drop", {31'd0, Bus_Req}, 32'd0);
        checkOutput("to_Bus_Err", {31'd0, Bus_Err}, 32'd1);
        checkOutput("to_IF_Data", IF_Data, 32'h0);
        checkOutput("to_IF_Valid", {31'd0, IF_Valid}, 32'd1);
        checkOutput("to_Freeze", {31'd0, Freeze}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("to_Bus_Err_end", {31'd0, Bus_Err}, 32'd0);
        tick();

        // Ack arriving on the last allowed cycle wins over the timeout.
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int c = 0; c < TO; c++) tick();
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("at_Bus_Err", {31'd0, Bus_Err}, 32'd0);
        checkOutput("at_IF_Data", IF_Data, 32'hCAFE_F00D);
        checkOutput("at_IF_Valid", {31'd0, IF_Valid}, 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();

        // Reset in the middle of a load; the load restarts from cycle 0 afterwards.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        tick();
        #1;
        checkOutput("rm_Req_before", {31'd0, Bus_Req}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rm_Req_fall", {31'd0, Bus_Req}, 32'd0);
        checkOutput("rm_Freeze_fall", {31'd0, Freeze}, 32'd0);
        modelReset();
        tick();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rm_c0_Freeze", {31'd0, Freeze}, 32'd1);
        checkOutput("rm_c0_Req", {31'd0, Bus_Req}, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h77);
        @(negedge clk);
        checkOutput("rm_c1_Req", {31'd0, Bus_Req}, 32'd1);
        checkOutput("rm_c1_Addr", Bus_Addr, 32'h40);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("rm_c2_MEM_RdData", MEM_RdData, 32'h77);
        checkOutput("rm_c2_MEM_Valid", {31'd0, MEM_Valid}, 32'd1);
        tick();

        // Random traffic; a store is always acknowledged by its last allowed cycle.
        for (int i = 0; i < 3000; i++) begin
            if (mBusy != 0) begin
                if (mWr && mAge == TO - 1) ackNow = 1'b1;
                else ackNow = ($urandom_range(0, 2) == 0);
            end else begin
                ackNow = ($urandom_range(0, 7) == 0);
            end
            applyStimulus(($urandom_range(0, 1) == 0), $urandom,
                          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                          $urandom, $urandom, ackNow, $urandom);
            @(negedge clk);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, variable-latency memory bus between the IF stage (instruction fetch) and the MEM stage (load/store). It raises a pipeline-wide freeze while either access is outstanding. It sits between the pipeline registers and the memory system. Its `Freeze` output drives the `Hold` of the IF/ID register and the clock-enable of PC, ID/EX, EX/MEM and MEM/WB. Data accesses take priority over fetches, and every access is bounded by a timeout.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles `Bus_Req` may stay high without `Bus_Ack` before the access is aborted; legal range 2..255.
- `CNT_W`, 8: width of the timeout counter.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `IF_Req`  in  1  fetch wanted this cycle.
- `IF_Addr`  in  32  fetch address.
- `IF_Data`  out  32  fetched instruction, valid while `IF_Valid`=1.
- `IF_Valid`  out  1  fetch of current instruction complete.
- `MEM_MemRd`, `MEM_MemWr`  in  1  load / store in MEM stage; both 1 is treated as write.
- `MEM_Addr`  in  32  data address.
- `MEM_WrData`  in  32  store data.
- `MEM_RdData`  out  32  load data, valid while `MEM_Valid`=1.
- `MEM_Valid`  out  1  data access of current instruction complete.
- `Bus_Req`  out  1  bus request.
- `Bus_Wr`  out  1  1 = write.
- `Bus_Addr`  out  32  bus address.
- `Bus_WrData`  out  32  bus write data.
- `Bus_RdData`  in  32  bus read data, valid with `Bus_Ack`.
- `Bus_Ack`  in  1  single-cycle completion pulse.
- `Freeze`  out  1  pipeline must hold.
- `Bus_Err`  out  1  one-cycle pulse on timeout abort.

## Operation
- **States:** IDLE, DATA, FETCH (registered).
- **Flags:**
  - `data_done` sets when a data access completes or aborts.
  - `if_done` sets when a fetch completes or aborts.
- **Pending conditions:**
  - `dpend` = (`MEM_MemRd`|`MEM_MemWr`) & !`data_done`.
  - `ipend` = `IF_Req` & !`if_done`.
- **Freeze** = `dpend` | `ipend` | (state≠IDLE). It is forced 0 while `reset`=0.
- **IDLE:**
  - If `dpend`, go to DATA. Latch `MEM_Addr`, `MEM_WrData` and write flag into `Bus_Addr`, `Bus_WrData`, `Bus_Wr`.
  - Else if `ipend`, go to FETCH. Latch `IF_Addr`, set `Bus_Wr`=0.
- **DATA/FETCH:**
  - `Bus_Req`=1; `Bus_Addr`, `Bus_Wr` and `Bus_WrData` are stable.
  - On `Bus_Ack`, capture `Bus_RdData` into `MEM_RdData` or `IF_Data` and set the matching done flag.
  - DATA with `ipend` goes directly to FETCH, latching `IF_Addr`. All other completions go to IDLE.
- **Timeout:**
  - The counter clears on state entry and increments each cycle in DATA/FETCH without `Bus_Ack`.
  - When it reaches `TIMEOUT`-1 without ack:
    - abort;
    - pulse `Bus_Err`;
    - load the read register with 32'h0;
    - set the done flag;
    - transition as on ack.
  - If `Bus_Ack` arrives in the same cycle as the timeout, the ack wins: no error, data captured.
- **Advance:** in a cycle where `Freeze`=0, both done flags clear at the closing edge, because the pipeline advances there.
- **Valid outputs:** `IF_Valid`=`if_done`, `MEM_Valid`=`data_done`.
- **Writes:** `MEM_RdData` is unchanged by writes.

## Timing
- **Reset values** (applied asynchronously on `reset` falling):
  - state = IDLE; both flags 0; counter 0.
  - `Bus_Req`, `Bus_Wr`, `Bus_Err`, `Freeze`, `IF_Valid`, `MEM_Valid` = 0.
  - `Bus_Addr`, `Bus_WrData`, `IF_Data`, `MEM_RdData` = 32'h0.
  - A bus transaction in flight is dropped; `Bus_Req` falls immediately.
- **Request/ack cycle sequence:**
  - Cycle 0: request seen, `Freeze`=1.
  - Cycle 1: `Bus_Req`=1.
  - Cycle n≥1: `Bus_Ack`.
  - Cycle n+1: data and Valid visible.
- **Minimum freeze:** 2 cycles per access; fetch plus data = 3 + both latencies.
- **Handshake:** `Bus_Req` never drops before ack or abort. `Bus_Ack` is ignored in IDLE.
- **Deassertion:** `Freeze` drops combinationally in the cycle after the final completion.
- **Mid-access request changes:** changes on `IF_*`/`MEM_*` during an access do not affect the bus registers.
- **Error pulse:** `Bus_Err` is high for exactly the cycle after the abort edge, aligned with Valid.

## Test plan
- **Fetch only:** `IF_Req`=1, `IF_Addr`=0x00400000, ack in cycle 2 with 0x8C080004 → `Bus_Req` high cycles 1–2, `Bus_Wr`=0, `IF_Data`=0x8C080004 and `Freeze`=0 in cycle 3.
- **Load and fetch in the same cycle:**
  - Setup: `MEM_MemRd`=1, `MEM_Addr`=0x10; acks return 0x55 and then 0x1234.
  - Required: data first with `Bus_Addr`=0x10; FETCH entered without IDLE.
  - Required: `MEM_RdData`=0x55, `IF_Data`=0x1234.
- **Store:** `MEM_MemWr`=1, `MEM_WrData`=0xDEADBEEF, `MEM_Addr`=0x20 → `Bus_Wr`=1 with stable address and data until ack; `MEM_RdData` unchanged.
- **Timeout:** `TIMEOUT`=4, no ack → `Bus_Req` high 4 cycles; `Bus_Err` one-cycle pulse; `IF_Data`=0; `Freeze` releases.
- **Ack on timeout cycle:** `Bus_Ack` coincides with the timeout cycle → no `Bus_Err`; data captured.
- **Reset mid-access:** `reset`=0 while in DATA → `Bus_Req` and `Freeze` fall immediately. After release, the pending load restarts from cycle 0.
